fetch_stage: RTL and testbench

Instruction-fetch controller between the program counter and the IF/ID boundary. Consumes the PC's current_count, runs a single-outstanding-request handshake to instruction memory, and computes the next PC value fed back to the PC's new_count. Owns the IF/ID pipeline register, a one-entry hold buffer for decode stalls, and branch/jump redirect and flush handling.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buffer_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: controller states,
// the default bubble instruction and the sequential PC increment.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INC            = 4;

endpackage

// File: rtl/fetch_buffer_reg.sv
// One {valid, instr, pc, pc4} pipeline slot. Flush beats load, load beats
// consume, otherwise the contents hold. A cleared slot always carries the
// bubble instruction so downstream never sees stale data.
module fetch_buffer_reg #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic               consume,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [ADDR_W-1:0]  load_pc4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc4
);

    logic               valid_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  pc4_reg;

    // Slot update: flush/consume empty the slot, load captures a new entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
            pc_reg    <= '0;
            pc4_reg   <= '0;
        end else if (flush || (consume && !load)) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= load_instr;
            pc_reg    <= load_pc;
            pc4_reg   <= load_pc4;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;
    assign pc4   = pc4_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch controller: single-outstanding memory handshake,
// next-PC selection, IF/ID register, one-entry stall buffer, and
// redirect/flush handling. A misaligned PC parks the stage in FAULT.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               id_stall,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               fetch_fault
);

    fetch_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  target_reg, target_next;
    logic               fault_reg, fault_next;

    logic [ADDR_W-1:0]  pc_plus4;
    logic               accept;
    logic               misaligned;

    logic               ifid_load;
    logic               ifid_from_hold;
    logic               hold_load;
    logic               hold_clear;

    logic               hold_valid;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;
    logic [ADDR_W-1:0]  hold_pc4;

    logic [INSTR_W-1:0] ifid_load_instr;
    logic [ADDR_W-1:0]  ifid_load_pc;
    logic [ADDR_W-1:0]  ifid_load_pc4;

    assign pc_plus4   = pc + ADDR_W'(PC_INC);
    assign accept     = !ifid_valid || !id_stall;
    assign misaligned = (pc[1:0] != 2'b00);
    // The request address is always the current PC; the PC is held while a
    // request is outstanding, which keeps the address stable.
    assign imem_addr  = pc;

    // Next-state, next-PC and datapath-control decode.
    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        fault_next     = fault_reg;
        next_pc        = pc;
        imem_req       = 1'b0;
        ifid_load      = 1'b0;
        ifid_from_hold = 1'b0;
        hold_load      = 1'b0;
        hold_clear     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (misaligned) begin
                    fault_next = 1'b1;
                    state_next = FAULT;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        if (redirect) begin
                            next_pc = redirect_target;
                        end else if (accept) begin
                            ifid_load = 1'b1;
                            next_pc   = pc_plus4;
                        end else begin
                            hold_load  = 1'b1;
                            next_pc    = pc_plus4;
                            state_next = HOLD;
                        end
                    end else if (redirect) begin
                        target_next = redirect_target;
                        state_next  = DISCARD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    hold_clear = 1'b1;
                    next_pc    = redirect_target;
                    state_next = FETCH;
                end else if (!id_stall) begin
                    ifid_load      = hold_valid;
                    ifid_from_hold = 1'b1;
                    hold_clear     = 1'b1;
                    state_next     = FETCH;
                end
            end
            DISCARD: begin
                imem_req = 1'b1;
                if (redirect) begin
                    target_next = redirect_target;
                end
                if (imem_ready) begin
                    next_pc    = redirect ? redirect_target : target_reg;
                    state_next = FETCH;
                end
            end
            FAULT: begin
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller state, saved redirect target and sticky fault flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            fault_reg  <= fault_next;
        end
    end

    assign fetch_fault     = fault_reg;
    assign ifid_load_instr = ifid_from_hold ? hold_instr : imem_rdata;
    assign ifid_load_pc    = ifid_from_hold ? hold_pc    : pc;
    assign ifid_load_pc4   = ifid_from_hold ? hold_pc4   : pc_plus4;

    fetch_buffer_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .flush      (hold_clear),
        .consume    (1'b0),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .load_pc4   (pc_plus4),
        .valid      (hold_valid),
        .instr      (hold_instr),
        .pc         (hold_pc),
        .pc4        (hold_pc4)
    );

    fetch_buffer_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load),
        .flush      (redirect),
        .consume    (!id_stall),
        .load_instr (ifid_load_instr),
        .load_pc    (ifid_load_pc),
        .load_pc4   (ifid_load_pc4),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc         (ifid_pc),
        .pc4        (ifid_pc4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against an instruction-stream model of the program flow.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        id_stall = 1'b0;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;
    int mem_wait = 0;
    int mem_cnt = 0;
    bit mem_busy = 1'b0;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_stall        (id_stall),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc4        (ifid_pc4),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // Program counter model: loads next_pc every edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) pc <= 32'h0;
        else        pc <= next_pc;
    end

    // Memory model: a request seen at a falling edge completes after
    // mem_wait extra cycles; data = addr ^ KEY. Dropped requests are forgotten.
    always @(negedge clk or negedge reset) begin
        if (!reset || !imem_req) begin
            mem_busy   <= 1'b0;
            mem_cnt    <= 0;
            imem_ready <= 1'b0;
        end else if (!mem_busy || imem_ready) begin
            mem_busy   <= 1'b1;
            mem_cnt    <= mem_wait;
            imem_ready <= (mem_wait == 0);
            imem_rdata <= imem_addr ^ KEY;
        end else begin
            mem_cnt    <= mem_cnt - 1;
            imem_ready <= (mem_cnt == 1);
            imem_rdata <= imem_addr ^ KEY;
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; redirect = 1'b0; redirect_target = 32'h0; id_stall = 1'b0; mem_wait = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #2;
    endtask

    // One cycle: inputs applied just after the falling edge, checks follow.
    task automatic cyc(input logic rd, input logic [31:0] tgt, input logic st);
        @(negedge clk);
        #1;
        redirect = rd; redirect_target = tgt; id_stall = st;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", ifid_valid); end
        checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL rst_instr got=%h exp=%h", ifid_instr, NOP); end
        checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", ifid_pc); end
        checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%h exp=0", ifid_pc4); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%0h exp=0", fetch_fault); end
        checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL rst_next_pc got=%h exp=0", next_pc); end
        @(negedge clk);
        reset = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%0h exp=0", imem_req); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 32'h0, 1'b0);
            checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL zw_addr k=%0d got=%h exp=%h", k, imem_addr, 32'(4 * k)); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req k=%0d got=%0h exp=1", k, imem_req); end
            checks++; if (next_pc !== 32'(4 * k + 4)) begin errors++; $display("FAIL zw_next_pc k=%0d got=%h exp=%h", k, next_pc, 32'(4 * k + 4)); end
            if (k > 0) begin
                checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL zw_valid k=%0d got=%0h exp=1", k, ifid_valid); end
                checks++; if (ifid_pc !== 32'(4 * (k - 1))) begin errors++; $display("FAIL zw_ifid_pc k=%0d got=%h exp=%h", k, ifid_pc, 32'(4 * (k - 1))); end
                checks++; if (ifid_pc4 !== 32'(4 * k)) begin errors++; $display("FAIL zw_ifid_pc4 k=%0d got=%h exp=%h", k, ifid_pc4, 32'(4 * k)); end
                checks++; if (ifid_instr !== (32'(4 * (k - 1)) ^ KEY)) begin errors++; $display("FAIL zw_instr k=%0d got=%h exp=%h", k, ifid_instr, 32'(4 * (k - 1)) ^ KEY); end
            end
        end
        $display("test_zero_wait done");
    endtask

    task automatic test_latency();
        do_reset();
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        mem_wait = 2;
        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, 32'h0, 1'b0);
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL lat_addr j=%0d got=%h exp=8", j, imem_addr); end
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req j=%0d got=%0h exp=1", j, imem_req); end
            checks++; if (next_pc !== ((j == 2) ? 32'hC : 32'h8)) begin errors++; $display("FAIL lat_next_pc j=%0d got=%h exp=%h", j, next_pc, (j == 2) ? 32'hC : 32'h8); end
            if (j == 1) begin
                checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL lat_bubble got=%h exp=%h", ifid_instr, NOP); end
            end
            if (j == 2) mem_wait = 0;
        end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%0h exp=1", ifid_valid); end
        checks++; if (ifid_pc !== 32'h8) begin errors++; $display("FAIL lat_ifid_pc got=%h exp=8", ifid_pc); end
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL lat_next_addr got=%h exp=c", imem_addr); end
        $display("test_latency done");
    endtask

    task automatic test_stall();
        do_reset();
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        checks++; if (next_pc !== 32'hC) begin errors++; $display("FAIL st_next_pc got=%h exp=c", next_pc); end
        checks++; if (ifid_pc !== 32'h4) begin errors++; $display("FAIL st_ifid_pc0 got=%h exp=4", ifid_pc); end
        cyc(1'b0, 32'h0, 1'b1);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_hold_req got=%0h exp=0", imem_req); end
        checks++; if (ifid_pc !== 32'h4) begin errors++; $display("FAIL st_ifid_pc1 got=%h exp=4", ifid_pc); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL st_valid got=%0h exp=1", ifid_valid); end
        checks++; if (next_pc !== 32'hC) begin errors++; $display("FAIL st_hold_next_pc got=%h exp=c", next_pc); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_rel_req got=%0h exp=0", imem_req); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (ifid_pc !== 32'h8) begin errors++; $display("FAIL st_ifid_pc2 got=%h exp=8", ifid_pc); end
        checks++; if (ifid_pc4 !== 32'hC) begin errors++; $display("FAIL st_ifid_pc4 got=%h exp=c", ifid_pc4); end
        checks++; if (ifid_instr !== (32'h8 ^ KEY)) begin errors++; $display("FAIL st_instr got=%h exp=%h", ifid_instr, 32'h8 ^ KEY); end
        checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL st_resume got=%h/%0h exp=c/1", imem_addr, imem_req); end
        $display("test_stall done");
    endtask

    task automatic test_redirect_pending();
        do_reset();
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        mem_wait = 2;
        cyc(1'b1, 32'h40, 1'b1);
        checks++; if (next_pc !== 32'h8) begin errors++; $display("FAIL rp_next_pc0 got=%h exp=8", next_pc); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rp_flush got=%0h exp=0", ifid_valid); end
        checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL rp_hold_addr got=%h/%0h exp=8/1", imem_addr, imem_req); end
        checks++; if (next_pc !== 32'h8) begin errors++; $display("FAIL rp_next_pc1 got=%h exp=8", next_pc); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL rp_addr2 got=%h exp=8", imem_addr); end
        checks++; if (next_pc !== 32'h40) begin errors++; $display("FAIL rp_next_pc2 got=%h exp=40", next_pc); end
        mem_wait = 0;
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL rp_new_addr got=%h exp=40", imem_addr); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rp_dropped got=%0h exp=0", ifid_valid); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40) begin errors++; $display("FAIL rp_target got=%0h/%h exp=1/40", ifid_valid, ifid_pc); end
        checks++; if (ifid_instr !== (32'h40 ^ KEY)) begin errors++; $display("FAIL rp_instr got=%h exp=%h", ifid_instr, 32'h40 ^ KEY); end
        $display("test_redirect_pending done");
    endtask

    task automatic test_redirect_ready();
        do_reset();
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 1'b0);
        checks++; if (imem_addr !== 32'hC || imem_ready !== 1'b1) begin errors++; $display("FAIL rr_setup got=%h/%0h exp=c/1", imem_addr, imem_ready); end
        checks++; if (next_pc !== 32'h100) begin errors++; $display("FAIL rr_next_pc got=%h exp=100", next_pc); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin errors++; $display("FAIL rr_dropped got=%0h/%h exp=0/%h", ifid_valid, ifid_instr, NOP); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rr_addr got=%h exp=100", imem_addr); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (ifid_pc !== 32'h100 || ifid_pc4 !== 32'h104) begin errors++; $display("FAIL rr_ifid got=%h/%h exp=100/104", ifid_pc, ifid_pc4); end
        $display("test_redirect_ready done");
    endtask

    task automatic test_wrap_fault();
        do_reset();
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        checks++; if (next_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wf_redirect got=%h exp=fffffffc", next_pc); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL wf_next_wrap got=%h exp=0", next_pc); end
        cyc(1'b1, 32'h6, 1'b0);
        checks++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0) begin errors++; $display("FAIL wf_pc4_wrap got=%h/%h exp=fffffffc/0", ifid_pc, ifid_pc4); end
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wf_misaligned_req got=%0h exp=0", imem_req); end
        for (int j = 0; j < 4; j++) begin
            cyc(j == 1, 32'h20, 1'b0);
            checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL wf_fault j=%0d got=%0h exp=1", j, fetch_fault); end
            checks++; if (imem_req !== 1'b0 || next_pc !== 32'h6) begin errors++; $display("FAIL wf_parked j=%0d got=%0h/%h exp=0/6", j, imem_req, next_pc); end
        end
        @(negedge clk);
        reset = 1'b0;
        #2;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL wf_reset_fault got=%0h exp=0", fetch_fault); end
        $display("test_wrap_fault done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b0, 32'h0, 1'b0);
        mem_wait = 4;
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_ready !== 1'b0) begin errors++; $display("FAIL rm_pending got=%0h/%0h exp=1/0", imem_req, imem_ready); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL rm_abandon got=%0h/%0h exp=0/0", imem_req, ifid_valid); end
        checks++; if (ifid_pc !== 32'h0 || ifid_instr !== NOP) begin errors++; $display("FAIL rm_ifid got=%h/%h exp=0/%h", ifid_pc, ifid_instr, NOP); end
        mem_wait = 0;
        @(negedge clk);
        reset = 1'b1;
        #2;
        cyc(1'b0, 32'h0, 1'b0);
        checks++; if (imem_addr !== 32'h0 || imem_ready !== 1'b1 || next_pc !== 32'h4) begin errors++; $display("FAIL rm_restart got=%h/%0h/%h exp=0/1/4", imem_addr, imem_ready, next_pc); end
        $display("test_reset_mid done");
    endtask

    // Random run. Model: decode must see the program in order -- each
    // consumed instruction is at the expected address, sequential by 4,
    // restarting at the target after every redirect -- with matching data.
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] prev_addr;
        logic        prev_req;
        logic        prev_ready;
        int          consumed;
        exp_next = 32'h0; prev_addr = 32'h0; prev_req = 1'b0; prev_ready = 1'b0; consumed = 0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            #1;
            redirect = (!imem_ready && ($urandom_range(0, 99) < 8));
            redirect_target = 32'($urandom_range(0, 63)) << 2;
            id_stall = ($urandom_range(0, 99) < 30);
            #1;
            if (prev_req && !prev_ready) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_handshake n=%0d got=%0h/%h exp=1/%h", n, imem_req, imem_addr, prev_addr); end
            end
            if (ifid_valid !== 1'b1) begin
                checks++; if (ifid_instr !== NOP) begin errors++; $display("FAIL rnd_bubble n=%0d got=%h exp=%h", n, ifid_instr, NOP); end
            end else if (!id_stall) begin
                checks++; if (ifid_pc !== exp_next) begin errors++; $display("FAIL rnd_order n=%0d got=%h exp=%h", n, ifid_pc, exp_next); end
                checks++; if (ifid_instr !== (exp_next ^ KEY) || ifid_pc4 !== exp_next + 32'h4) begin errors++; $display("FAIL rnd_data n=%0d got=%h/%h exp=%h/%h", n, ifid_instr, ifid_pc4, exp_next ^ KEY, exp_next + 32'h4); end
                exp_next = exp_next + 32'h4;
                consumed++;
            end
            if (redirect) exp_next = redirect_target;
            prev_req = imem_req; prev_ready = imem_ready; prev_addr = imem_addr;
            mem_wait = $urandom_range(0, 3);
        end
        redirect = 1'b0; id_stall = 1'b0;
        checks++; if (consumed < 50) begin errors++; $display("FAIL rnd_progress got=%0d exp>=50", consumed); end
        $display("test_random done consumed=%0d", consumed);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect_pending();
        test_redirect_ready();
        test_wrap_fault();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
